// File: rtl/i2c_txn_scheduler_if.sv
// Host, poller and I2C-master signals of the transaction scheduler.
// slave = scheduler side, master = requester / master-model side.
interface i2c_txn_scheduler_if #(
   parameter int N_POLL = 4
);
   logic                host_req;
   logic                host_rnw;
   logic [6:0]          host_adr;
   logic [31:0]         host_wr_data;
   logic [2:0]          host_bytes;
   logic                host_ack;
   logic                host_err;
   logic [31:0]         host_rd_data;
   logic [N_POLL-1:0]   poll_en;
   logic [7*N_POLL-1:0] poll_adr;
   logic                poll_we;
   logic [2:0]          poll_idx;
   logic [15:0]         poll_data;
   logic                poll_err;
   logic                poll_overrun;
   logic [6:0]          m_adr;
   logic                m_wr_flg;
   logic                m_rd_flg;
   logic [31:0]         m_wr_data;
   logic [2:0]          m_wr_bytes;
   logic [2:0]          m_rd_bytes;
   logic [3:0]          m_rd_channels;
   logic [31:0]         m_rd_data;
   logic                m_rd_data_en;
   logic                m_busy;

   modport slave (
      input  host_req, host_rnw, host_adr, host_wr_data, host_bytes,
      output host_ack, host_err, host_rd_data,
      input  poll_en, poll_adr,
      output poll_we, poll_idx, poll_data, poll_err, poll_overrun,
      output m_adr, m_wr_flg, m_rd_flg, m_wr_data,
      output m_wr_bytes, m_rd_bytes, m_rd_channels,
      input  m_rd_data, m_rd_data_en, m_busy
   );

   modport master (
      output host_req, host_rnw, host_adr, host_wr_data, host_bytes,
      input  host_ack, host_err, host_rd_data,
      output poll_en, poll_adr,
      input  poll_we, poll_idx, poll_data, poll_err, poll_overrun,
      input  m_adr, m_wr_flg, m_rd_flg, m_wr_data,
      input  m_wr_bytes, m_rd_bytes, m_rd_channels,
      output m_rd_data, m_rd_data_en, m_busy
   );
endinterface

// File: rtl/i2c_txn_scheduler.sv
// Shares one I2C master between host requests and a periodic 2-byte poller.
// Define I2C_SCHED_POLL_EN to build the poller; otherwise poll outputs are tied 0.
module i2c_txn_scheduler #(
   parameter int N_POLL      = 4,
   parameter int POLL_PERIOD = 40000000,
   parameter int START_TMO   = 8,
   parameter int TXN_TMO     = 200000
) (
   input logic clk,
   input logic reset,
   i2c_txn_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_t;

   localparam int TMAX = (TXN_TMO > START_TMO + 2) ? TXN_TMO : START_TMO + 2;
   localparam int TW   = $clog2(TMAX + 1);

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic          cur_host;
   logic          cur_rnw;
   logic          got_data;
   logic [31:0]   rd_buf;
   logic [31:0]   rd_now;
   logic          have_data;
   logic          fin;
   logic          fin_err;
   logic [2:0]    host_len;

   assign bus.m_rd_channels = 4'd1;
   assign rd_now    = got_data ? rd_buf : bus.m_rd_data;
   assign have_data = got_data | bus.m_rd_data_en;

   always_comb begin
      host_len = bus.host_bytes;
      if (bus.host_bytes == 3'd0 || bus.host_bytes > 3'd4)
         host_len = 3'd2;
   end

   // busy is the master's registered reply, so allow one extra sample cycle
   always_comb begin
      fin     = 1'b0;
      fin_err = 1'b0;
      unique case (state)
         WAIT_BUSY:
            if (!bus.m_busy && tmo_cnt == TW'(START_TMO + 1)) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
         RUN:
            if (!bus.m_busy || tmo_cnt == TW'(TXN_TMO - 1)) begin
               fin     = 1'b1;
               fin_err = bus.m_busy | (cur_rnw & ~have_data);
            end
         default: ;
      endcase
   end

`ifdef I2C_SCHED_POLL_EN
   localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

   logic [PW-1:0]     per_cnt;
   logic              tick;
   logic [N_POLL-1:0] pend;
   logic [2:0]        cur_idx;
   logic [2:0]        nxt_idx;
   logic [6:0]        nxt_adr;
   logic              sweeping;

   assign tick = (per_cnt == PW'(POLL_PERIOD - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         per_cnt <= '0;
      else if (tick)
         per_cnt <= '0;
      else
         per_cnt <= per_cnt + PW'(1);
   end

   always_comb begin
      nxt_idx = '0;
      for (int i = N_POLL - 1; i >= 0; i--)
         if (pend[i]) nxt_idx = 3'(i);
      nxt_adr = bus.poll_adr[7*nxt_idx +: 7];
   end

   // the last slot's transaction still belongs to the sweep
   assign sweeping = (|pend) | (state != IDLE && !cur_host);
`else
   logic unused_poll;
   assign unused_poll       = ^{bus.poll_en, bus.poll_adr};
   assign bus.poll_we       = 1'b0;
   assign bus.poll_idx      = 3'd0;
   assign bus.poll_data     = 16'd0;
   assign bus.poll_err      = 1'b0;
   assign bus.poll_overrun  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         tmo_cnt          <= '0;
         cur_host         <= 1'b0;
         cur_rnw          <= 1'b0;
         got_data         <= 1'b0;
         rd_buf           <= '0;
         bus.m_adr        <= '0;
         bus.m_wr_flg     <= 1'b0;
         bus.m_rd_flg     <= 1'b0;
         bus.m_wr_data    <= '0;
         bus.m_wr_bytes   <= '0;
         bus.m_rd_bytes   <= 3'd2;
         bus.host_ack     <= 1'b0;
         bus.host_err     <= 1'b0;
         bus.host_rd_data <= '0;
`ifdef I2C_SCHED_POLL_EN
         pend             <= '0;
         cur_idx          <= '0;
         bus.poll_we      <= 1'b0;
         bus.poll_idx     <= '0;
         bus.poll_data    <= '0;
         bus.poll_err     <= 1'b0;
         bus.poll_overrun <= 1'b0;
`endif
      end else begin
         bus.m_wr_flg <= 1'b0;
         bus.m_rd_flg <= 1'b0;
         bus.host_ack <= 1'b0;
`ifdef I2C_SCHED_POLL_EN
         bus.poll_we <= 1'b0;
         if (tick) begin
            if (sweeping)
               bus.poll_overrun <= 1'b1;
            else
               pend <= bus.poll_en;
         end
`endif
         if (fin) begin
            state <= DONE;
            if (cur_host) begin
               bus.host_ack     <= 1'b1;
               bus.host_err     <= fin_err;
               bus.host_rd_data <= cur_rnw ? rd_now : 32'd0;
            end
`ifdef I2C_SCHED_POLL_EN
            else begin
               bus.poll_we   <= 1'b1;
               bus.poll_err  <= fin_err;
               bus.poll_idx  <= cur_idx;
               bus.poll_data <= rd_now[31:16];
            end
`endif
         end else begin
            unique case (state)
               IDLE:
                  if (!bus.m_busy) begin
                     if (bus.host_req) begin
                        state     <= ISSUE;
                        cur_host  <= 1'b1;
                        cur_rnw   <= bus.host_rnw;
                        bus.m_adr <= bus.host_adr;
                        if (bus.host_rnw)
                           bus.m_rd_bytes <= host_len;
                        else begin
                           bus.m_wr_data  <= bus.host_wr_data;
                           bus.m_wr_bytes <= bus.host_bytes;
                        end
                     end
`ifdef I2C_SCHED_POLL_EN
                     else if (|pend) begin
                        state          <= ISSUE;
                        cur_host       <= 1'b0;
                        cur_rnw        <= 1'b1;
                        cur_idx        <= nxt_idx;
                        bus.m_adr      <= nxt_adr;
                        bus.m_rd_bytes <= 3'd2;
                        pend <= pend & ~(N_POLL'(1) << nxt_idx);
                     end
`endif
                  end
               ISSUE: begin
                  bus.m_rd_flg <= cur_rnw;
                  bus.m_wr_flg <= ~cur_rnw;
                  tmo_cnt      <= '0;
                  got_data     <= 1'b0;
                  state        <= WAIT_BUSY;
               end
               WAIT_BUSY:
                  if (bus.m_busy) begin
                     tmo_cnt <= '0;
                     state   <= RUN;
                  end else
                     tmo_cnt <= tmo_cnt + TW'(1);
               RUN: begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (bus.m_rd_data_en && !got_data) begin
                     rd_buf   <= bus.m_rd_data;
                     got_data <= 1'b1;
                  end
               end
               DONE:
                  state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a behavioural I2C master model.
// Poll scenarios run when I2C_SCHED_POLL_EN is defined; otherwise poll outputs must stay 0.
module tb_i2c_txn_scheduler;
   localparam int START_TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_wr = 0;
   int   n_rd = 0;
   int   n_ack = 0;
   int   fall_cyc = 0;
   logic busy_q = 1'b0;

   int   model_mode = 0;
   int   model_len = 5;
   logic [31:0] model_data = 32'h0;

   int   pw_idx[$];
   int   pw_data[$];
   int   pw_err[$];
   int   pw_cyc[$];

   i2c_txn_scheduler_if #(.N_POLL(4)) ifc ();

   i2c_txn_scheduler #(
      .N_POLL(4), .POLL_PERIOD(1000),
      .START_TMO(START_TMO), .TXN_TMO(50)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .bus(ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      busy_q <= ifc.m_busy;
      if (busy_q && !ifc.m_busy) fall_cyc <= cyc;
   end

   always @(negedge clk) begin
      if (ifc.m_wr_flg) n_wr <= n_wr + 1;
      if (ifc.m_rd_flg) n_rd <= n_rd + 1;
      if (ifc.host_ack) n_ack <= n_ack + 1;
      if (ifc.poll_we) begin
         pw_idx.push_back(int'(ifc.poll_idx));
         pw_data.push_back(int'(ifc.poll_data));
         pw_err.push_back(int'(ifc.poll_err));
         pw_cyc.push_back(cyc);
      end
   end

   // mode 0 normal, 1 never busy, 2 long busy, 3 busy without read data
   initial begin
      logic rd;
      ifc.m_busy = 1'b0;
      ifc.m_rd_data_en = 1'b0;
      ifc.m_rd_data = 32'h0;
      forever begin
         @(negedge clk);
         if (ifc.m_wr_flg || ifc.m_rd_flg) begin
            rd = ifc.m_rd_flg;
            if (model_mode != 1) begin
               @(negedge clk);
               ifc.m_busy = 1'b1;
               repeat (model_len) @(negedge clk);
               if (rd && model_mode != 3) begin
                  ifc.m_rd_data = model_data;
                  ifc.m_rd_data_en = 1'b1;
                  @(negedge clk);
                  ifc.m_rd_data_en = 1'b0;
               end
               ifc.m_busy = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic host_txn(input logic rnw, input logic [6:0] adr,
                           input logic [31:0] wd, input logic [2:0] nb,
                           output logic err, output logic [31:0] rd,
                           output int lat, output int dur,
                           output logic bflag);
      int t;
      int req_c;
      int flag_c;
      @(negedge clk);
      ifc.host_rnw = rnw;
      ifc.host_adr = adr;
      ifc.host_wr_data = wd;
      ifc.host_bytes = nb;
      ifc.host_req = 1'b1;
      req_c = cyc;
      flag_c = -1;
      bflag = 1'b1;
      t = 0;
      while (!ifc.host_ack && t < 1000) begin
         @(negedge clk);
         t++;
         if (flag_c < 0 && (ifc.m_wr_flg || ifc.m_rd_flg)) begin
            flag_c = cyc;
            bflag = ifc.m_busy;
         end
      end
      check("ack_seen", ifc.host_ack, 1'b1);
      err = ifc.host_err;
      rd = ifc.host_rd_data;
      lat = flag_c - req_c;
      dur = cyc - flag_c;
      ifc.host_req = 1'b0;
   endtask

   initial begin
      logic        err;
      logic [31:0] rd;
      int          lat;
      int          dur;
      logic        bf;
      int          w0;
      int          r0;
      int          a0;
      int          t;
      logic [2:0]  nb_v[4];
      logic [2:0]  nb_e[4];
      nb_v = '{3'd3, 3'd0, 3'd4, 3'd7};
      nb_e = '{3'd3, 3'd2, 3'd4, 3'd2};

      ifc.host_req = 1'b0;
      ifc.host_rnw = 1'b0;
      ifc.host_adr = '0;
      ifc.host_wr_data = '0;
      ifc.host_bytes = '0;
      ifc.poll_en = 4'b0000;
      ifc.poll_adr = {7'h13, 7'h12, 7'h11, 7'h10};

      repeat (3) @(negedge clk);
      check("rst_ack", ifc.host_ack, 1'b0);
      check("rst_chan", ifc.m_rd_channels, 4'd1);
      check("rst_rdbytes", ifc.m_rd_bytes, 3'd2);
      check("rst_flags", {ifc.m_wr_flg, ifc.m_rd_flg}, 2'b00);
      check("rst_overrun", ifc.poll_overrun, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      w0 = n_wr;
      r0 = n_rd;
      host_txn(1'b0, 7'h48, 32'hA55A0000, 3'd2, err, rd, lat, dur, bf);
      check("wr_err", err, 1'b0);
      check("wr_flg_once", n_wr - w0, 1);
      check("wr_no_rdflg", n_rd - r0, 0);
      check("wr_bytes", ifc.m_wr_bytes, 3'd2);
      check("wr_adr", ifc.m_adr, 7'h48);
      check("wr_data", ifc.m_wr_data, 32'hA55A0000);
      check("req_to_flag", lat, 2);
      check("ack_after_fall", cyc - fall_cyc, 1);

      model_data = 32'h12340000;
      w0 = n_wr;
      r0 = n_rd;
      host_txn(1'b1, 7'h40, 32'h0, 3'd2, err, rd, lat, dur, bf);
      check("rd_data", rd, 32'h12340000);
      check("rd_err", err, 1'b0);
      check("rd_flg_once", n_rd - r0, 1);
      check("rd_no_wrflg", n_wr - w0, 0);
      check("rd_bytes", ifc.m_rd_bytes, 3'd2);

      for (int i = 0; i < 4; i++) begin
         model_data = 32'h0BAD0000 + i;
         host_txn(1'b1, 7'h41, 32'h0, nb_v[i], err, rd, lat, dur, bf);
         check("rd_bytes_norm", ifc.m_rd_bytes, nb_e[i]);
         check("rd_data_n", rd, 32'h0BAD0000 + i);
      end

      model_mode = 3;
      host_txn(1'b1, 7'h42, 32'h0, 3'd2, err, rd, lat, dur, bf);
      check("nodata_err", err, 1'b1);

      model_mode = 1;
      host_txn(1'b0, 7'h43, 32'h1, 3'd1, err, rd, lat, dur, bf);
      check("start_tmo_err", err, 1'b1);
      check("start_tmo_cyc", dur, START_TMO + 2);

      model_mode = 2;
      model_len = 80;
      host_txn(1'b0, 7'h44, 32'h2, 3'd1, err, rd, lat, dur, bf);
      check("txn_tmo_err", err, 1'b1);
      check("tmo_busy_high", ifc.m_busy, 1'b1);
      model_mode = 0;
      model_len = 5;
      host_txn(1'b0, 7'h45, 32'h3, 3'd1, err, rd, lat, dur, bf);
      check("blk_err", err, 1'b0);
      check("blk_busy_at_flag", bf, 1'b0);
      check("blk_waited", lat > 20, 1'b1);

      model_mode = 2;
      model_len = 200;
      @(negedge clk);
      ifc.host_rnw = 1'b1;
      ifc.host_adr = 7'h22;
      ifc.host_bytes = 3'd4;
      ifc.host_req = 1'b1;
      t = 0;
      while (!ifc.m_busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("rst_run_busy", ifc.m_busy, 1'b1);
      repeat (5) @(negedge clk);
      check("pre_rst_adr", ifc.m_adr, 7'h22);
      a0 = n_ack;
      #2 rst_n = 1'b0;
      #1;
      check("async_adr", ifc.m_adr, 7'h00);
      check("async_rdbytes", ifc.m_rd_bytes, 3'd2);
      check("async_ack", ifc.host_ack, 1'b0);
      ifc.host_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("no_ack_after_rst", n_ack - a0, 0);
      model_mode = 0;
      model_len = 5;

`ifdef I2C_SCHED_POLL_EN
      model_data = 32'hBEEF0000;
      pw_idx.delete(); pw_data.delete(); pw_err.delete(); pw_cyc.delete();
      @(negedge clk);
      ifc.poll_en = 4'b0101;
      t = 0;
      while (pw_idx.size() < 4 && t < 2500) begin
         @(negedge clk);
         t++;
      end
      check("poll_cnt", pw_idx.size(), 4);
      if (pw_idx.size() >= 4) begin
         check("poll_idx0", pw_idx[0], 0);
         check("poll_idx1", pw_idx[1], 2);
         check("poll_data0", pw_data[0], 32'hBEEF);
         check("poll_data1", pw_data[1], 32'hBEEF);
         check("poll_err0", pw_err[0], 0);
         check("poll_period", pw_cyc[2] - pw_cyc[0], 1000);
         check("poll_idx2", pw_idx[2], 0);
      end
      check("poll_rdbytes", ifc.m_rd_bytes, 3'd2);

      pw_idx.delete(); pw_data.delete(); pw_err.delete(); pw_cyc.delete();
      t = 0;
      while (!(ifc.m_rd_flg && ifc.m_adr == 7'h10) && t < 1500) begin
         @(negedge clk);
         t++;
      end
      check("slot0_flag", ifc.m_rd_flg, 1'b1);
      ifc.host_rnw = 1'b0;
      ifc.host_adr = 7'h50;
      ifc.host_bytes = 3'd1;
      ifc.host_req = 1'b1;
      a0 = -1;
      t = 0;
      while ((a0 < 0 || pw_idx.size() < 2) && t < 300) begin
         @(negedge clk);
         t++;
         if (ifc.host_ack && a0 < 0) begin
            a0 = cyc;
            ifc.host_req = 1'b0;
         end
      end
      ifc.host_req = 1'b0;
      check("il_count", pw_idx.size(), 2);
      if (pw_idx.size() >= 2) begin
         check("il_first", pw_idx[0], 0);
         check("il_second", pw_idx[1], 2);
         check("il_ack_after0", a0 > pw_cyc[0], 1'b1);
         check("il_ack_before2", a0 < pw_cyc[1], 1'b1);
      end

      check("ovr_clear", ifc.poll_overrun, 1'b0);
      pw_idx.delete(); pw_data.delete(); pw_err.delete(); pw_cyc.delete();
      model_mode = 2;
      model_len = 600;
      t = 0;
      while (!ifc.poll_overrun && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("ovr_set", ifc.poll_overrun, 1'b1);
      model_mode = 0;
      model_len = 5;
      t = 0;
      while (pw_idx.size() < 2 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("ovr_cnt", pw_idx.size() >= 2, 1'b1);
      if (pw_idx.size() >= 1)
         check("ovr_tmo_err", pw_err[0], 1);
      repeat (1500) @(negedge clk);
      check("ovr_sticky", ifc.poll_overrun, 1'b1);
`else
      r0 = n_rd;
      @(negedge clk);
      ifc.poll_en = 4'b0101;
      repeat (1200) @(negedge clk);
      check("nopoll_we", pw_idx.size(), 0);
      check("nopoll_rdflg", n_rd - r0, 0);
      check("nopoll_ovr", ifc.poll_overrun, 1'b0);
      check("nopoll_data", ifc.poll_data, 16'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_txn_scheduler.md
# i2c_txn_scheduler

Transaction scheduler in front of `i2c_master_if`. Shares the single I2C master between a host requester (SiTCP RBCP register path) and an internal periodic poller that reads 2-byte monitor values from up to `N_POLL` slave addresses. Sequences each transaction: single-cycle flag pulse, waits for busy, captures read data, reports completion or error. Owns all master control inputs; nothing else drives the master.

## Interface
- `N_POLL`, 4: number of poll slots (1–8).
- `POLL_PERIOD`, 40000000: clk cycles between poll sweeps (1 s at 40 MHz).
- `START_TMO`, 8: max cycles from flag pulse to `m_busy`=1.
- `TXN_TMO`, 200000: max cycles with `m_busy`=1 per transaction.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `host_req` in 1: level; held until `host_ack`.
- `host_rnw` in 1: 1 = read, 0 = write.
- `host_adr` in 7: slave address.
- `host_wr_data` in 32: write bytes, MSB first.
- `host_bytes` in 3: byte count, 1–4.
- `host_ack` out 1: one-cycle completion pulse.
- `host_err` out 1: valid with `host_ack`; 1 = timeout or missing read data.
- `host_rd_data` out 32: valid with `host_ack` on reads.
- `poll_en` in N_POLL: per-slot enable.
- `poll_adr` in 7*N_POLL: slot i address at [7i+6:7i].
- `poll_we` out 1: one-cycle poll result strobe.
- `poll_idx` out 3: slot of current result.
- `poll_data` out 16: 2-byte result.
- `poll_err` out 1: valid with `poll_we`.
- `poll_overrun` out 1: sticky; set when a tick arrives mid-sweep; cleared only by reset.
- `m_adr` out 7, `m_wr_flg` out 1, `m_rd_flg` out 1, `m_wr_data` out 32, `m_wr_bytes` out 3, `m_rd_bytes` out 3, `m_rd_channels` out 4: master controls.
- `m_rd_data` in 32, `m_rd_data_en` in 1, `m_busy` in 1: master status.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE: waits for `m_busy`=0. Then host pending beats poll pending; latches adr/rnw/data/bytes into the `m_*` registers and goes to ISSUE.
- Host priority is checked before every poll slot, so host transactions interleave within a sweep.
- ISSUE: asserts exactly one of `m_wr_flg`/`m_rd_flg` for one cycle, then goes to WAIT_BUSY.
- WAIT_BUSY: `m_busy`=1 goes to RUN. Timeout after `START_TMO` cycles sets err and goes to DONE.
- RUN: the first `m_rd_data_en` pulse captures `m_rd_data`; later pulses are ignored.
  - `m_busy` falling goes to DONE.
  - `TXN_TMO` expiry sets err and goes to DONE.
  - A read with no capture sets err.
- DONE: one cycle. Pulses `host_ack` or `poll_we` with err and data, then returns to IDLE.
- Master setup: `m_rd_channels` is fixed at 1. Polls use `m_rd_bytes`=2. Host reads use `host_bytes`, which is forced to 2 if it is 0 or >4.
- Poller: a free-running counter wraps at `POLL_PERIOD`-1 and emits a tick.
  - A tick starts a sweep over enabled slots in ascending index; disabled slots are skipped in 0 cycles.
  - A tick during a sweep is dropped and sets `poll_overrun`.
  - A tick with `poll_en`=0 is a no-op.
- `poll_data` = `m_rd_data[31:16]`.

## Timing
- Reset values:
  - All outputs 0, except `m_rd_channels`=1 and `m_rd_bytes`=2.
  - FSM = IDLE; counters = 0.
- All outputs are registered.
- `host_req` seen in IDLE gives the flag pulse 2 cycles later (IDLE→ISSUE→flag).
- Flag is high for exactly 1 cycle, with `m_adr`/data stable from the cycle before until `m_busy` falls.
- `host_ack` is asserted the cycle after the `m_busy` falling edge is sampled.
- The host must drop `host_req` the cycle after `host_ack`. A still-high `host_req` in the next IDLE is a new request.
- A timeout leaves `m_busy` possibly high. IDLE then blocks until `m_busy`=0.
- The period counter runs during transactions and never stalls.
- Reset mid-transaction returns to IDLE immediately. No ack is issued.

## Configuration
- `I2C_SCHED_POLL_EN` defined: poller, period counter and poll outputs are present as above.
- Undefined: poller logic is removed. `poll_we`, `poll_idx`, `poll_data`, `poll_err` and `poll_overrun` are tied 0, and the host path is unchanged.

## Test plan
- Host write, adr 0x48, bytes 2, data 0xA55A0000 → single 1-cycle `m_wr_flg`, `m_wr_bytes`=2; `host_ack`=1, `host_err`=0 one cycle after busy falls.
- Host read, adr 0x40, master model returns 0x12340000 → `host_rd_data`=0x12340000, `host_err`=0.
- `POLL_PERIOD`=1000, `poll_en`=4'b0101, model returns 0xBEEF0000 → `poll_we` twice per period with `poll_idx` 0 then 2, `poll_data`=0xBEEF.
- `host_req` raised during slot-0 poll → host transaction runs before slot 2; `poll_we` for slot 2 follows `host_ack`.
- Model never raises `m_busy` → `host_err`=1 exactly `START_TMO`+2 cycles after the flag. Separately, `POLL_PERIOD` shorter than a sweep → `poll_overrun`=1 and stays 1.
- Reset asserted during RUN → all outputs return to reset values asynchronously and no `host_ack` is issued.
